// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: synchronizes irq lines, picks the EX slot
// to take a trap, and drives the CSR trap interface plus the PC redirect.
module irq_trap_ctrl #(
   parameter int SYNC_STAGES    = 2,
   parameter bit MTVEC_VECTORED = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ext_irq,
   input  logic        tim_irq,
   input  logic        sw_irq,
   input  logic        csr_gmie,
   input  logic        csr_meie,
   input  logic        csr_mtie,
   input  logic        csr_msie,
   input  logic [29:0] csr_mtvec_ex,
   input  logic [29:0] csr_mepc,
   input  logic        valid_ex,
   input  logic        stall,
   input  logic        cmd_ecall_ex,
   input  logic        cmd_mret_ex,
   output logic        g_interrupt,
   output logic [1:0]  g_interrupt_priv,
   output logic [1:0]  g_current_priv,
   output logic [3:0]  int_cause,
   output logic        trap_jmp,
   output logic [29:0] trap_jmp_adr,
   output logic        irq_busy
);

   // state   | meaning
   // IDLE    | no handler running, watching for a pending interrupt
   // ARM     | interrupt pending, waiting for an unstalled real instruction in EX
   // HANDLER | trap handler running, interrupts held off until mret
   typedef enum logic [1:0] {IDLE, ARM, HANDLER} state_t;

   state_t state, state_nxt;
   logic [3:0] cause_nxt;
   logic [SYNC_STAGES-1:0] sync_e, sync_t, sync_s;
   logic pend_e, pend_t, pend_s, any_pend;
   logic ecall_go, take;
   logic [3:0] win_cause;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_e <= '0;
         sync_t <= '0;
         sync_s <= '0;
      end else begin
         sync_e <= {sync_e[SYNC_STAGES-2:0], ext_irq};
         sync_t <= {sync_t[SYNC_STAGES-2:0], tim_irq};
         sync_s <= {sync_s[SYNC_STAGES-2:0], sw_irq};
      end
   end

   assign pend_e   = sync_e[SYNC_STAGES-1] & csr_meie;
   assign pend_t   = sync_t[SYNC_STAGES-1] & csr_mtie;
   assign pend_s   = sync_s[SYNC_STAGES-1] & csr_msie;
   assign any_pend = csr_gmie & (pend_e | pend_s | pend_t);

   // external beats software beats timer
   always_comb begin
      win_cause = 4'd0;
      if (pend_e)      win_cause = 4'd11;
      else if (pend_s) win_cause = 4'd3;
      else if (pend_t) win_cause = 4'd7;
   end

   assign ecall_go = cmd_ecall_ex & valid_ex & ~stall;
   assign take     = ~stall & valid_ex & ~cmd_ecall_ex & ~cmd_mret_ex;

   assign g_interrupt_priv = 2'b11;
   assign g_current_priv   = 2'b11;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         int_cause <= 4'd0;
      end else begin
         state     <= state_nxt;
         int_cause <= cause_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cause_nxt    = int_cause;
      g_interrupt  = 1'b0;
      trap_jmp     = 1'b0;
      trap_jmp_adr = 30'd0;
      irq_busy     = (state == HANDLER);
      if (!stall) begin
         case (state)
            IDLE: begin
               if (ecall_go) begin
                  trap_jmp     = 1'b1;
                  trap_jmp_adr = csr_mtvec_ex;
                  state_nxt    = HANDLER;
               end else if (any_pend) begin
                  state_nxt = ARM;
               end
            end
            ARM: begin
               // ecall wins; the interrupt stays pending and is retaken after mret
               if (ecall_go) begin
                  trap_jmp     = 1'b1;
                  trap_jmp_adr = csr_mtvec_ex;
                  state_nxt    = HANDLER;
               end else if (!any_pend) begin
                  state_nxt = IDLE;
               end else if (take) begin
                  g_interrupt  = 1'b1;
                  trap_jmp     = 1'b1;
                  trap_jmp_adr = MTVEC_VECTORED ? (csr_mtvec_ex + {26'd0, win_cause})
                                                : csr_mtvec_ex;
                  cause_nxt    = win_cause;
                  state_nxt    = HANDLER;
               end
            end
            HANDLER: begin
               if (cmd_mret_ex) begin
                  trap_jmp     = 1'b1;
                  trap_jmp_adr = csr_mepc;
                  cause_nxt    = 4'd0;
                  state_nxt    = IDLE;
               end else if (ecall_go) begin
                  trap_jmp     = 1'b1;
                  trap_jmp_adr = csr_mtvec_ex;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
